// File: rtl/spu_nearest_tracker.sv
// Nearest-distance tracker: per frame, keeps the smallest SPU distance, its first index and a sample count.
// Optional running sum of tracked samples is enabled by defining SPU_TRACKER_SUM_EN.
module spu_nearest_tracker #(
  parameter int DIST_W = 8,
  parameter int IDX_W  = 6,
  parameter int SUM_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dist_valid,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_last,
  output logic              dist_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DIST_W-1:0] min_dist,
  output logic [IDX_W-1:0]  min_idx,
  output logic [IDX_W:0]    count,
  output logic              overflow,
  output logic              busy
`ifdef SPU_TRACKER_SUM_EN
  ,
  output logic [SUM_W-1:0]  sum_out
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W:0] CAP = {1'b1, {IDX_W{1'b0}}};

  state_t              r_state;
  logic [DIST_W-1:0]   r_min;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W:0]      r_count;
  logic                r_ovf;

  logic                w_accept;
  logic                w_full;
  logic                w_open;

  assign w_accept = dist_valid && (r_state == ACCUM);
  assign w_full   = (r_count == CAP);
  // A new frame opens from IDLE, or directly from DONE when the result handshake coincides with start.
  assign w_open   = start && ((r_state == IDLE) || ((r_state == DONE) && res_ready));

`ifdef SPU_TRACKER_SUM_EN
  logic [SUM_W-1:0]    r_sum;
  logic [SUM_W:0]      w_sum_add;
  logic [SUM_W-1:0]    w_sum_sat;

  assign w_sum_add = {1'b0, r_sum} + (SUM_W+1)'(dist_in);
  assign w_sum_sat = w_sum_add[SUM_W] ? '1 : w_sum_add[SUM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_open) begin
      r_sum <= '0;
    end else if (w_accept && !w_full) begin
      r_sum <= w_sum_sat;
    end
  end

  assign sum_out = r_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_min   <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_open) begin
      r_state <= ACCUM;
      r_min   <= '1;
      r_idx   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= IDLE;
        ACCUM: begin
          if (w_accept) begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_count <= r_count + (IDX_W+1)'(1);
              if (dist_in < r_min) begin
                r_min <= dist_in;
                r_idx <= r_count[IDX_W-1:0];
              end
            end
            if (dist_last) r_state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dist_ready = (r_state == ACCUM);
  assign res_valid  = (r_state == DONE);
  assign busy       = (r_state == ACCUM) || (r_state == DONE);
  assign min_dist   = r_min;
  assign min_idx    = r_idx;
  assign count      = r_count;
  assign overflow   = r_ovf;

endmodule

// File: doc/spu_nearest_tracker.md
SPU_NEAREST_TRACKER -- requirements
Module: spu_nearest_tracker

Interface
REQ-001 Parameter DIST_W, default 8, sets the width of the distance samples (matches the SPU distance output byte).
REQ-002 Parameter IDX_W, default 6, sets the sample index width; a frame holds at most 2^IDX_W tracked samples.
REQ-003 Parameter SUM_W, default 14, sets the width of the running-sum accumulator (SPU_TRACKER_SUM_EN builds only).
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port start, input, 1 bit: single-cycle pulse that opens a new frame.
REQ-007 Port dist_valid, input, 1 bit: dist_in carries a sample.
REQ-008 Port dist_in, input, DIST_W bits: distance sample from the SPU stage.
REQ-009 Port dist_last, input, 1 bit: qualified by dist_valid; marks the final sample of the frame.
REQ-010 Port dist_ready, output, 1 bit: tracker accepts a sample this cycle.
REQ-011 Port res_valid, output, 1 bit: the frame result is available.
REQ-012 Port res_ready, input, 1 bit: consumer accepts the result.
REQ-013 Port min_dist, output, DIST_W bits: smallest accepted distance in the frame.
REQ-014 Port min_idx, output, IDX_W bits: zero-based index of the first sample equal to min_dist.
REQ-015 Port count, output, IDX_W+1 bits: number of samples tracked in the frame.
REQ-016 Port overflow, output, 1 bit: the frame exceeded 2^IDX_W samples.
REQ-017 Port busy, output, 1 bit: high while in state ACCUM or DONE.

Function
REQ-018 FSM states SHALL be IDLE, ACCUM and DONE; dist_ready = (state==ACCUM); res_valid = (state==DONE).
REQ-019 IDLE + start SHALL transition to ACCUM, with min_dist=all ones, min_idx=0, count=0, overflow=0 and sum=0 on the same edge.
REQ-020 A sample is accepted on a cycle where dist_valid && dist_ready; while count < 2^IDX_W, an accepted sample SHALL increment count.
REQ-021 An accepted sample with dist_in < min_dist (strict) SHALL load min_dist=dist_in and min_idx=count (pre-increment value); on a tie the earlier index is kept.
REQ-022 A sample accepted while count == 2^IDX_W SHALL be consumed but not compared; it SHALL leave count unchanged and set overflow=1 (sticky until the next start).
REQ-023 An accepted sample with dist_last=1 SHALL be included in the result and move the FSM to DONE; res_valid SHALL rise on the next cycle (1-cycle latency).
REQ-024 In DONE, min_dist, min_idx, count, overflow and sum SHALL hold stable until res_valid && res_ready; the handshake returns the FSM to IDLE.
REQ-025 start SHALL be ignored in ACCUM. In DONE, start is ignored unless the result handshake occurs in the same cycle, in which case the FSM goes directly to ACCUM with cleared registers.
REQ-026 A frame whose only sample carries dist_last SHALL report that sample with min_idx=0 and count=1.
REQ-027 dist_in = all ones SHALL never update the minimum (not strictly less than the initial value); if every sample is all ones, the result is min_dist=all ones with min_idx=0.

Reset
REQ-028 rst_n low SHALL, asynchronously, force state IDLE, all result registers to 0 (min_dist also 0), overflow=0, dist_ready=0, res_valid=0 and busy=0.
REQ-029 rst_n low in ACCUM or DONE SHALL abort the frame; no result is emitted afterwards, and a new start is required.
REQ-030 Release of rst_n SHALL take effect on the first clk edge with rst_n high; the design needs no synchronous initialisation cycle.

Configuration
REQ-031 With macro SPU_TRACKER_SUM_EN defined, the block SHALL add output port sum_out (SUM_W bits) that accumulates each tracked sample, saturates at 2^SUM_W-1 and holds in DONE.
REQ-032 Without SPU_TRACKER_SUM_EN, the block SHALL have no sum_out port and no accumulator logic; all other behaviour is identical.

Verification
REQ-033 Reset, start, then samples 9,4,7,4(last) -> res_valid one cycle after last accepted, min_dist=4, min_idx=1, count=4, overflow=0 (sum_out=24 if enabled).
REQ-034 Start, single sample 0x3C with dist_last=1 -> min_dist=0x3C, min_idx=0, count=1.
REQ-035 IDX_W=2, start, 6 samples 5,5,5,5,1,2(last) -> min_dist=5, min_idx=0, count=4, overflow=1.
REQ-036 In DONE, hold res_ready=0 for 5 cycles -> outputs stable; then pulse res_ready with start -> next cycle busy=1, count=0, dist_ready=1.
REQ-037 Drop rst_n mid-frame after 2 samples -> dist_ready=0, res_valid=0 immediately; after release, no res_valid until a new start and frame.
